// File: rtl/reg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_ctrl
// Purpose  : Avalon-MM slave bridging single-word accesses onto a bank of
//            shadow registers (one-hot select, held read strobe, write pulse).
// Revision : 1.0
// ============================================================================
module reg_access_ctrl #(
  parameter int P_WIDTH        = 32,
  parameter int P_NUM_REGS     = 8,
  parameter int P_ADDR_WIDTH   = 3,
  parameter int P_READ_LATENCY = 2
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic [P_ADDR_WIDTH-1:0]       AVMM_ADDRESS,
  input  logic                          AVMM_READ,
  input  logic                          AVMM_WRITE,
  input  logic [P_WIDTH-1:0]            AVMM_WRITEDATA,
  output logic                          AVMM_WAITREQUEST,
  output logic [P_WIDTH-1:0]            AVMM_READDATA,
  output logic                          AVMM_READDATAVALID,
  output logic [P_NUM_REGS-1:0]         REG_SELECT,
  output logic                          REG_READ,
  output logic                          REG_WRITE,
  output logic [P_WIDTH-1:0]            REG_WRDATA,
  input  logic [P_NUM_REGS*P_WIDTH-1:0] REG_RDDATA
);

  localparam logic [3:0] c_LAT_LOAD = 4'(P_READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_HOLD = 2'd1,
    S_RD_DONE = 2'd2,
    S_WR      = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [P_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [P_NUM_REGS-1:0]     sel_q, sel_d;
  logic                      rd_q, rd_d;
  logic                      wr_q, wr_d;
  logic [P_WIDTH-1:0]        wrdata_q, wrdata_d;
  logic [P_WIDTH-1:0]        rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic                      wait_q, wait_d;

  logic [P_NUM_REGS-1:0]     cmd_sel;
  logic [P_WIDTH-1:0]        rd_slice;

  // Out-of-range addresses decode to an all-zero select.
  function automatic logic [P_NUM_REGS-1:0] decode(input logic [P_ADDR_WIDTH-1:0] addr);
    logic [P_NUM_REGS-1:0] oh;
    oh = '0;
    for (int n = 0; n < P_NUM_REGS; n++) begin
      oh[n] = (addr == P_ADDR_WIDTH'(n));
    end
    return oh;
  endfunction

  assign cmd_sel = decode(AVMM_ADDRESS);

  always_comb begin
    rd_slice = '0;
    for (int n = 0; n < P_NUM_REGS; n++) begin
      if (addr_q == P_ADDR_WIDTH'(n)) begin
        rd_slice = REG_RDDATA[n*P_WIDTH +: P_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    rd_d     = rd_q;
    wr_d     = 1'b0;
    wrdata_d = wrdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A read wins over a simultaneous write; the write is dropped.
        if (!wait_q && AVMM_READ) begin
          state_d = S_RD_HOLD;
          addr_d  = AVMM_ADDRESS;
          cnt_d   = c_LAT_LOAD;
          sel_d   = cmd_sel;
          rd_d    = 1'b1;
        end else if (!wait_q && AVMM_WRITE) begin
          state_d  = S_WR;
          addr_d   = AVMM_ADDRESS;
          sel_d    = cmd_sel;
          wr_d     = |cmd_sel;
          wrdata_d = AVMM_WRITEDATA;
        end
      end
      S_RD_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RD_DONE;
          rdata_d  = rd_slice;
          rvalid_d = 1'b1;
          sel_d    = '0;
          rd_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RD_DONE: begin
        state_d = S_IDLE;
      end
      S_WR: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        rd_d    = 1'b0;
      end
    endcase

    wait_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      sel_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wrdata_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wait_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wrdata_q <= wrdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wait_q   <= wait_d;
    end
  end

  assign AVMM_WAITREQUEST   = wait_q;
  assign AVMM_READDATA      = rdata_q;
  assign AVMM_READDATAVALID = rvalid_q;
  assign REG_SELECT         = sel_q;
  assign REG_READ           = rd_q;
  assign REG_WRITE          = wr_q;
  assign REG_WRDATA         = wrdata_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_access_ctrl
// Purpose  : Scoreboard bench for reg_access_ctrl with a transaction-level
//            reference model and randomized master traffic.
// Revision : 1.0
// ============================================================================
module tb_reg_access_ctrl;

  localparam int TB_W    = 32;
  localparam int TB_N    = 6;
  localparam int TB_AW   = 3;
  localparam int TB_L    = 2;
  localparam int MAXC    = 16384;
  localparam int K_RD    = 0;
  localparam int K_WR    = 1;
  localparam int K_RST   = 2;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] data;
    bit          wr_en;
  } item_t;

  bit                      clk = 1'b0;
  logic                    RESET;
  logic [TB_AW-1:0]        AVMM_ADDRESS;
  logic                    AVMM_READ;
  logic                    AVMM_WRITE;
  logic [TB_W-1:0]         AVMM_WRITEDATA;
  logic                    AVMM_WAITREQUEST;
  logic [TB_W-1:0]         AVMM_READDATA;
  logic                    AVMM_READDATAVALID;
  logic [TB_N-1:0]         REG_SELECT;
  logic                    REG_READ;
  logic                    REG_WRITE;
  logic [TB_W-1:0]         REG_WRDATA;
  logic [TB_N*TB_W-1:0]    REG_RDDATA;

  logic [TB_W-1:0]         regval [TB_N];
  bit                      exp_wait [MAXC];
  bit                      exp_rd   [MAXC];
  bit   [TB_N-1:0]         exp_sel  [MAXC];
  item_t                   sb [$];
  int                      cyc = 0;
  int                      free_at = 0;
  int                      n_total = 0;
  int                      n_bad = 0;
  logic [TB_W-1:0]         held_rd;
  logic [TB_W-1:0]         held_wr;

  reg_access_ctrl #(
    .P_WIDTH        (TB_W),
    .P_NUM_REGS     (TB_N),
    .P_ADDR_WIDTH   (TB_AW),
    .P_READ_LATENCY (TB_L)
  ) dut (
    .CLOCK              (clk),
    .RESET              (RESET),
    .AVMM_ADDRESS       (AVMM_ADDRESS),
    .AVMM_READ          (AVMM_READ),
    .AVMM_WRITE         (AVMM_WRITE),
    .AVMM_WRITEDATA     (AVMM_WRITEDATA),
    .AVMM_WAITREQUEST   (AVMM_WAITREQUEST),
    .AVMM_READDATA      (AVMM_READDATA),
    .AVMM_READDATAVALID (AVMM_READDATAVALID),
    .REG_SELECT         (REG_SELECT),
    .REG_READ           (REG_READ),
    .REG_WRITE          (REG_WRITE),
    .REG_WRDATA         (REG_WRDATA),
    .REG_RDDATA         (REG_RDDATA)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    REG_RDDATA = '0;
    for (int n = 0; n < TB_N; n++) REG_RDDATA[n*TB_W +: TB_W] = regval[n];
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit [TB_N-1:0] onehot(input int addr);
    bit [TB_N-1:0] v;
    v = '0;
    if (addr < TB_N) v[addr] = 1'b1;
    return v;
  endfunction

  // Monitor: pops whatever the model says is due this cycle, then compares.
  always @(negedge clk) begin
    item_t it;
    bit    e_rv;
    bit    e_wr;
    if (cyc >= 1 && cyc < MAXC) begin
      e_rv = 1'b0;
      e_wr = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        if (it.kind == K_RD) begin
          e_rv    = 1'b1;
          held_rd = it.data;
        end else if (it.kind == K_WR) begin
          e_wr    = it.wr_en;
          held_wr = it.data;
        end else begin
          held_rd = '0;
          held_wr = '0;
        end
      end
      chk("waitrequest",   64'(AVMM_WAITREQUEST),   64'(exp_wait[cyc]));
      chk("reg_read",      64'(REG_READ),           64'(exp_rd[cyc]));
      chk("reg_select",    64'(REG_SELECT),         64'(exp_sel[cyc]));
      chk("readdatavalid", 64'(AVMM_READDATAVALID), 64'(e_rv));
      chk("reg_write",     64'(REG_WRITE),          64'(e_wr));
      chk("readdata",      64'(AVMM_READDATA),      64'(held_rd));
      chk("reg_wrdata",    64'(REG_WRDATA),         64'(held_wr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    item_t it;
    int    c0;
    c0 = cyc;
    RESET      = 1'b1;
    AVMM_READ  = 1'b0;
    AVMM_WRITE = 1'b0;
    while (sb.size() > 0 && sb[sb.size()-1].due > c0) void'(sb.pop_back());
    for (int c = c0 + 1; c < MAXC; c++) begin
      exp_wait[c] = 1'b0;
      exp_rd[c]   = 1'b0;
      exp_sel[c]  = '0;
    end
    for (int c = c0 + 1; c <= c0 + n; c++) exp_wait[c] = 1'b1;
    it.due = c0 + 1; it.kind = K_RST; it.data = '0; it.wr_en = 1'b0;
    sb.push_back(it);
    repeat (n) tick();
    RESET   = 1'b0;
    free_at = cyc + 1;
  endtask

  // Master holds the request until the model's acceptance cycle.
  task automatic issue(input bit rd, input bit wr, input int addr, input logic [31:0] data);
    item_t it;
    int    a;
    a = (cyc > free_at) ? cyc : free_at;
    AVMM_READ      = rd;
    AVMM_WRITE     = wr;
    AVMM_ADDRESS   = TB_AW'(addr);
    AVMM_WRITEDATA = data;
    if (rd) begin
      for (int k = 1; k <= TB_L; k++) begin
        exp_wait[a+k] = 1'b1;
        exp_rd[a+k]   = 1'b1;
        exp_sel[a+k]  = onehot(addr);
      end
      exp_wait[a+TB_L+1] = 1'b1;
      it.due   = a + TB_L + 1;
      it.kind  = K_RD;
      it.data  = (addr < TB_N) ? regval[addr] : 32'h0;
      it.wr_en = 1'b0;
      free_at  = a + TB_L + 2;
    end else begin
      exp_wait[a+1] = 1'b1;
      exp_sel[a+1]  = onehot(addr);
      it.due   = a + 1;
      it.kind  = K_WR;
      it.data  = data;
      it.wr_en = (addr < TB_N);
      free_at  = a + 2;
    end
    sb.push_back(it);
    while (cyc <= a) tick();
    AVMM_READ      = 1'b0;
    AVMM_WRITE     = 1'b0;
    AVMM_ADDRESS   = TB_AW'($urandom_range(0, 7));
    AVMM_WRITEDATA = $urandom;
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    int addr;
    AVMM_READ      = 1'b0;
    AVMM_WRITE     = 1'b0;
    AVMM_ADDRESS   = '0;
    AVMM_WRITEDATA = '0;
    for (int n = 0; n < TB_N; n++) regval[n] = $urandom;
    regval[3] = 32'hDEADBEEF;
    do_reset(3);

    issue(1'b1, 1'b0, 3, 32'h0);
    repeat (4) tick();
    issue(1'b0, 1'b1, 5, 32'h12345678);
    tick();
    issue(1'b1, 1'b0, 7, 32'h0);
    issue(1'b0, 1'b1, 6, 32'hCAFEF00D);
    issue(1'b1, 1'b1, 1, 32'h55AA55AA);
    issue(1'b1, 1'b0, 0, 32'h0);
    issue(1'b1, 1'b0, 1, 32'h0);
    repeat (3) tick();

    issue(1'b1, 1'b0, 2, 32'h0);
    tick();
    do_reset(2);
    issue(1'b1, 1'b0, 4, 32'h0);

    for (int i = 0; i < 250; i++) begin
      if (cyc >= free_at && $urandom_range(0, 1) == 1)
        regval[$urandom_range(0, TB_N-1)] = $urandom;
      kind = $urandom_range(0, 9);
      addr = $urandom_range(0, 7);
      if (kind <= 3)      issue(1'b1, 1'b0, addr, $urandom);
      else if (kind <= 7) issue(1'b0, 1'b1, addr, $urandom);
      else if (kind == 8) issue(1'b1, 1'b1, addr, $urandom);
      else begin
        issue(1'b1, 1'b0, addr, $urandom);
        repeat ($urandom_range(0, 3)) tick();
        do_reset($urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    while (cyc < free_at + 2) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter P_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter P_NUM_REGS, default 8, number of attached registers (1..64).
REQ-003 SHALL have parameter P_ADDR_WIDTH, default 3, word address width; 2**P_ADDR_WIDTH >= P_NUM_REGS.
REQ-004 SHALL have parameter P_READ_LATENCY, default 2, number of cycles REG_READ is held before capture (1..15).
REQ-005 SHALL have port CLOCK  in  1  sole clock, rising edge.
REQ-006 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-007 SHALL have port AVMM_ADDRESS  in  P_ADDR_WIDTH  word address.
REQ-008 SHALL have port AVMM_READ  in  1  read request.
REQ-009 SHALL have port AVMM_WRITE  in  1  write request.
REQ-010 SHALL have port AVMM_WRITEDATA  in  P_WIDTH  write data.
REQ-011 SHALL have port AVMM_WAITREQUEST  out  1  command not accepted this cycle.
REQ-012 SHALL have port AVMM_READDATA  out  P_WIDTH  read response data.
REQ-013 SHALL have port AVMM_READDATAVALID  out  1  one-cycle read response strobe.
REQ-014 SHALL have port REG_SELECT  out  P_NUM_REGS  one-hot register select.
REQ-015 SHALL have port REG_READ  out  1  read strobe; holds the selected shadow register stable.
REQ-016 SHALL have port REG_WRITE  out  1  one-cycle write strobe.
REQ-017 SHALL have port REG_WRDATA  out  P_WIDTH  write data to registers.
REQ-018 SHALL have port REG_RDDATA  in  P_NUM_REGS*P_WIDTH  flattened register outputs; register n at bits [n*P_WIDTH +: P_WIDTH].

Function
REQ-019 SHALL implement FSM states IDLE, RD_HOLD, RD_DONE, WR; all outputs registered.
REQ-020 SHALL drive AVMM_WAITREQUEST low only in IDLE; a command is accepted when (AVMM_READ or AVMM_WRITE) is high and AVMM_WAITREQUEST is low.
REQ-021 SHALL, on read acceptance in cycle 0: latch address, enter RD_HOLD, and drive REG_SELECT one-hot and REG_READ=1 in cycles 1..P_READ_LATENCY.
REQ-022 SHALL use a 4-bit down-counter loaded with P_READ_LATENCY-1; in the RD_HOLD cycle where the counter is 0, capture the addressed REG_RDDATA slice and go to RD_DONE.
REQ-023 SHALL, in RD_DONE (cycle P_READ_LATENCY+1), drive AVMM_READDATAVALID=1 with AVMM_READDATA = captured value, deassert REG_SELECT and REG_READ, then return to IDLE.
REQ-024 SHALL hold AVMM_READDATA at the last captured value until the next capture.
REQ-025 SHALL, on write acceptance in cycle 0: latch address and data, enter WR; in cycle 1 drive REG_SELECT one-hot, REG_WRITE=1, REG_WRDATA = latched data; return to IDLE in cycle 2.
REQ-026 SHALL keep REG_WRDATA at the last written value outside WR.
REQ-027 SHALL treat simultaneous AVMM_READ and AVMM_WRITE as a read; the write is dropped.
REQ-028 SHALL, for address >= P_NUM_REGS: read runs with normal timing, REG_SELECT all zero, REG_READ=1, AVMM_READDATA=0; write runs WR timing with REG_SELECT=0 and REG_WRITE=0.
REQ-029 SHALL ignore requests while AVMM_WAITREQUEST is high; the master holds them until accepted.
REQ-030 SHALL never assert REG_READ and REG_WRITE in the same cycle; REG_SELECT has at most one bit set.

Reset
REQ-031 SHALL, while RESET is high at a rising edge, set state IDLE, counter 0, REG_SELECT=0, REG_READ=0, REG_WRITE=0, REG_WRDATA=0, AVMM_READDATA=0, AVMM_READDATAVALID=0, AVMM_WAITREQUEST=1.
REQ-032 SHALL deassert AVMM_WAITREQUEST at the first edge with RESET low, so no command is accepted in the first cycle after reset release.
REQ-033 SHALL abort any in-flight access on RESET with no AVMM_READDATAVALID and no REG_WRITE emitted.

Verification
REQ-034 SHALL pass: read addr 3, REG_RDDATA slice 3 = 0xDEADBEEF, L=2 -> REG_SELECT=0x08, REG_READ high cycles 1-2, READDATAVALID cycle 3 with 0xDEADBEEF, WAITREQUEST high cycles 1-3.
REQ-035 SHALL pass: write addr 5 data 0x12345678 -> cycle 1 REG_SELECT=0x20, REG_WRITE=1, REG_WRDATA=0x12345678; WAITREQUEST high cycle 1 only.
REQ-036 SHALL pass: read addr 7 with P_NUM_REGS=6 -> REG_SELECT=0, READDATAVALID cycle 3 with 0x0; write addr 6 -> REG_WRITE never high.
REQ-037 SHALL pass: READ and WRITE both high, addr 1 -> read sequence only, REG_WRITE stays 0.
REQ-038 SHALL pass: RESET high in cycle 2 of a read (L=4) -> next cycle REG_READ=0, REG_SELECT=0, WAITREQUEST=1, no READDATAVALID; first command after release accepted no earlier than the second cycle with RESET low.
REQ-039 SHALL pass: back-to-back reads addr 0 then 1 held by master -> second accepted in the cycle after READDATAVALID of the first.
